// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_mem_pkg
//  Brief    : Shared op encodings, FSM state type and decode helpers for the
//             load/store unit.
//  Revision : 1.0
// ============================================================================
package mips_mem_pkg;

    localparam logic [2:0] c_op_lb  = 3'd0;
    localparam logic [2:0] c_op_lh  = 3'd1;
    localparam logic [2:0] c_op_lw  = 3'd2;
    localparam logic [2:0] c_op_lbu = 3'd3;
    localparam logic [2:0] c_op_lhu = 3'd4;
    localparam logic [2:0] c_op_sb  = 3'd5;
    localparam logic [2:0] c_op_sh  = 3'd6;
    localparam logic [2:0] c_op_sw  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    function automatic logic is_store(input logic [2:0] op);
        return (op == c_op_sb) || (op == c_op_sh) || (op == c_op_sw);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] adr_lo);
        logic r;
        r = 1'b0;
        case (op)
            c_op_lh, c_op_lhu, c_op_sh: r = adr_lo[0];
            c_op_lw, c_op_sw:           r = (adr_lo != 2'b00);
            default:                    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_lane_fmt.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_lane_fmt
//  Brief    : Byte/halfword lane extraction with extension, and sub-word
//             merge of store data into a read word.
//  Revision : 1.0
// ============================================================================
module lsu_lane_fmt
    import mips_mem_pkg::*;
#(
    parameter int BIG_ENDIAN = 1
) (
    input  logic [31:0] word,
    input  logic [1:0]  adr_lo,
    input  logic [2:0]  op,
    input  logic [31:0] wdat,
    output logic [31:0] ld_data,
    output logic [31:0] st_data
);

    logic [1:0]  w_byte_lane;
    logic        w_half_lane;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane numbers count from bit 0 upward; big-endian offset 0 is the top lane.
    assign w_byte_lane = (BIG_ENDIAN != 0) ? ~adr_lo    : adr_lo;
    assign w_half_lane = (BIG_ENDIAN != 0) ? ~adr_lo[1] : adr_lo[1];
    assign w_byte      = word[{w_byte_lane, 3'b000} +: 8];
    assign w_half      = word[{w_half_lane, 4'b0000} +: 16];

    always_comb begin
        ld_data = word;
        case (op)
            c_op_lb:  ld_data = {{24{w_byte[7]}}, w_byte};
            c_op_lbu: ld_data = {24'h0, w_byte};
            c_op_lh:  ld_data = {{16{w_half[15]}}, w_half};
            c_op_lhu: ld_data = {16'h0, w_half};
            default:  ld_data = word;
        endcase
    end

    always_comb begin
        st_data = wdat;
        case (op)
            c_op_sb: begin
                st_data = word;
                st_data[{w_byte_lane, 3'b000} +: 8] = wdat[7:0];
            end
            c_op_sh: begin
                st_data = word;
                st_data[{w_half_lane, 4'b0000} +: 16] = wdat[15:0];
            end
            default: st_data = wdat;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : mem_lsu
//  Brief    : Single-outstanding load/store unit in front of a word memory;
//             sub-word stores are done as read-modify-write.
//  Revision : 1.0
// ============================================================================
module mem_lsu
    import mips_mem_pkg::*;
#(
    parameter int MEM_IDX_W  = 6,
    parameter int BIG_ENDIAN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_wdat,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdat,
    output logic        rsp_misalign,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdat,
    input  logic [31:0] mem_rdat,
    output logic        mem_R,
    output logic        mem_W
);

    lsu_state_t  r_state;
    lsu_state_t  w_state_nxt;

    logic [2:0]  r_op;
    logic [1:0]  r_adr_lo;
    logic [31:0] r_wdat;
    logic [31:0] r_rdat;
    logic        r_misalign;
    logic [31:0] r_mem_adr;
    logic [31:0] r_mem_wdat;

    logic        w_accept;
    logic        w_req_mis;
    logic [31:0] w_ld_data;
    logic [31:0] w_st_data;
    logic        w_unused_adr;

    assign w_accept  = req_valid && (r_state == ST_IDLE);
    assign w_req_mis = is_misaligned(req_op, req_adr[1:0]);

    // Address bits beyond the memory's decoded range are deliberately dropped.
    assign w_unused_adr = ^req_adr[31:MEM_IDX_W+2];

    lsu_lane_fmt #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_lane_fmt (
        .word    (mem_rdat),
        .adr_lo  (r_adr_lo),
        .op      (r_op),
        .wdat    (r_wdat),
        .ld_data (w_ld_data),
        .st_data (w_st_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_req_mis)
                        w_state_nxt = ST_RESP;
                    else if (req_op == c_op_sw)
                        w_state_nxt = ST_WR;
                    else
                        w_state_nxt = ST_RD;
                end
            end
            ST_RD:   w_state_nxt = is_store(r_op) ? ST_WR : ST_RESP;
            ST_WR:   w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_op       <= 3'd0;
            r_adr_lo   <= 2'd0;
            r_wdat     <= 32'h0;
            r_rdat     <= 32'h0;
            r_misalign <= 1'b0;
            r_mem_adr  <= 32'h0;
            r_mem_wdat <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op       <= req_op;
                r_adr_lo   <= req_adr[1:0];
                r_wdat     <= req_wdat;
                r_rdat     <= 32'h0;
                r_misalign <= w_req_mis;
                // Faulting requests leave the memory-side bus untouched.
                if (!w_req_mis) begin
                    r_mem_adr <= {{(32-MEM_IDX_W){1'b0}}, req_adr[MEM_IDX_W+1:2]};
                    if (req_op == c_op_sw)
                        r_mem_wdat <= req_wdat;
                end
            end
            if (r_state == ST_RD) begin
                if (is_store(r_op))
                    r_mem_wdat <= w_st_data;
                else
                    r_rdat <= w_ld_data;
            end
        end
    end

    assign req_ready    = (r_state == ST_IDLE);
    assign rsp_valid    = (r_state == ST_RESP);
    assign rsp_rdat     = r_rdat;
    assign rsp_misalign = r_misalign;
    assign mem_adr      = r_mem_adr;
    assign mem_wdat     = r_mem_wdat;
    assign mem_R        = (r_state == ST_RD);
    assign mem_W        = (r_state == ST_WR);

endmodule
`default_nettype wire
